adbg_sel_hub: RTL and testbench

Parametrised JTAG debug top-level hub for the advanced debug interface. It sits between the TAP controller and NB_MODULES debug sub-modules (AXI, per-cluster CPU, and others). It owns the shared DR input shift register, the module-ID select register and the TDO return mux. Unlike the fixed two-module top level, it rejects out-of-range and inhibited selects, and it reports the outcome of each select command through a status word shifted out on the following DR scan.

---
 rtl/adbg_sel_hub.sv | 104 ++++++++++
 tb/tb_adbg_sel_hub.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adbg_sel_hub.sv
// rtl/adbg_sel_hub.sv - JTAG debug hub: shared DR shift register, checked module select, status readback and TDO mux
module adbg_sel_hub #(
    parameter int NB_MODULES     = 4,
    parameter int MODID_W        = 5,
    parameter int DATA_LEN       = 64,
    parameter int DEFAULT_MODULE = 0
) (
    input  logic                  tck_i,
    input  logic                  trstn_i,
    input  logic                  tdi_i,
    output logic                  tdo_o,
    input  logic                  shift_dr_i,
    input  logic                  capture_dr_i,
    input  logic                  update_dr_i,
    input  logic                  debug_select_i,
    output logic [DATA_LEN-1:0]   data_register_o,
    output logic [NB_MODULES-1:0] module_select_o,
    input  logic [NB_MODULES-1:0] module_tdo_i,
    input  logic [NB_MODULES-1:0] module_inhibit_i,
    output logic [MODID_W-1:0]    module_id_o
);

    localparam int                 STAT_W         = MODID_W + 3;
    // One extra bit so NB_MODULES == 2**MODID_W still compares correctly
    localparam logic [MODID_W:0]   NB_MODULES_EXT = (MODID_W + 1)'(NB_MODULES);
    localparam logic [MODID_W-1:0] DEFAULT_ID     = MODID_W'(DEFAULT_MODULE);

    logic [DATA_LEN-1:0]   sr;
    logic [MODID_W-1:0]    module_id_reg;
    logic [1:0]            status_err;
    logic                  status_pending;
    logic                  status_mode;
    logic [STAT_W-1:0]     stat_sr;
    logic [NB_MODULES-1:0] mod_onehot;
    logic                  mod_tdo;

    logic                  sel_cmd;
    logic [MODID_W-1:0]    id_in;
    logic                  sel_update;
    logic                  dbg_shift;

    assign sel_cmd    = sr[DATA_LEN-1];
    assign id_in      = sr[DATA_LEN-2 -: MODID_W];
    assign sel_update = update_dr_i & debug_select_i & sel_cmd;
    assign dbg_shift  = shift_dr_i & debug_select_i;

    always_ff @(posedge tck_i or negedge trstn_i) begin
        if (!trstn_i) begin
            sr             <= '0;
            module_id_reg  <= DEFAULT_ID;
            status_err     <= 2'b00;
            status_pending <= 1'b0;
            status_mode    <= 1'b0;
            stat_sr        <= '0;
        end else begin
            if (dbg_shift) begin
                sr <= {tdi_i, sr[DATA_LEN-1:1]};
            end

            if (sel_update) begin
                status_pending <= 1'b1;
                if (|module_inhibit_i) begin
                    status_err <= 2'b01;
                end else if ({1'b0, id_in} >= NB_MODULES_EXT) begin
                    status_err <= 2'b10;
                end else begin
                    module_id_reg <= id_in;
                    status_err    <= 2'b00;
                end
            end else if (capture_dr_i && debug_select_i && status_pending) begin
                stat_sr        <= {status_err, module_id_reg, 1'b1};
                status_mode    <= 1'b1;
                status_pending <= 1'b0;
            end

            if (dbg_shift && status_mode) begin
                stat_sr <= {1'b0, stat_sr[STAT_W-1:1]};
            end

            // Leaving the status scan wins over any capture seen on the same edge
            if (update_dr_i && debug_select_i) begin
                status_mode <= 1'b0;
            end
        end
    end

    // Loop decode keeps the TDO mux from ever indexing past the last module
    always_comb begin
        mod_onehot = '0;
        mod_tdo    = 1'b0;
        for (int i = 0; i < NB_MODULES; i++) begin
            if (module_id_reg == MODID_W'(i)) begin
                mod_onehot[i] = 1'b1;
                mod_tdo       = module_tdo_i[i];
            end
        end
    end

    assign module_select_o = mod_onehot & {NB_MODULES{~(status_pending | status_mode)}};
    assign tdo_o           = status_mode ? stat_sr[0] : mod_tdo;
    assign data_register_o = sr;
    assign module_id_o     = module_id_reg;

endmodule

// File: tb/tb_adbg_sel_hub.sv
// tb/tb_adbg_sel_hub.sv - scoreboard bench for adbg_sel_hub
module tb_adbg_sel_hub;

    logic        tck_i = 1'b0;
    logic        trstn_i = 1'b0;
    logic        tdi_i = 1'b0;
    logic        tdo_o;
    logic        shift_dr_i = 1'b0;
    logic        capture_dr_i = 1'b0;
    logic        update_dr_i = 1'b0;
    logic        debug_select_i = 1'b1;
    logic [63:0] data_register_o;
    logic [3:0]  module_select_o;
    logic [3:0]  module_tdo_i = 4'b0001;
    logic [3:0]  module_inhibit_i = 4'b0000;
    logic [4:0]  module_id_o;

    adbg_sel_hub #(
        .NB_MODULES(4),
        .MODID_W(5),
        .DATA_LEN(64),
        .DEFAULT_MODULE(0)
    ) dut (
        .tck_i(tck_i),
        .trstn_i(trstn_i),
        .tdi_i(tdi_i),
        .tdo_o(tdo_o),
        .shift_dr_i(shift_dr_i),
        .capture_dr_i(capture_dr_i),
        .update_dr_i(update_dr_i),
        .debug_select_i(debug_select_i),
        .data_register_o(data_register_o),
        .module_select_o(module_select_o),
        .module_tdo_i(module_tdo_i),
        .module_inhibit_i(module_inhibit_i),
        .module_id_o(module_id_o)
    );

    always #5 tck_i = ~tck_i;

    localparam int K_TDO = 0;
    localparam int K_SEL = 1;
    localparam int K_ID  = 2;
    localparam int K_DR  = 3;

    typedef struct {
        string       name;
        int          kind;
        logic [63:0] exp;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic [63:0] mon_act;
    int n_checks = 0;
    int n_err = 0;

    always @(negedge tck_i) begin
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            case (mon_e.kind)
                K_TDO:   mon_act = {63'd0, tdo_o};
                K_SEL:   mon_act = {60'd0, module_select_o};
                K_ID:    mon_act = {59'd0, module_id_o};
                default: mon_act = data_register_o;
            endcase
            n_checks++;
            if (mon_act !== mon_e.exp) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", mon_e.name, mon_act, mon_e.exp);
            end
        end
    end

    task automatic push(input string name, input int kind, input logic [63:0] exp);
        exp_t t;
        t.name = name;
        t.kind = kind;
        t.exp  = exp;
        exp_q.push_back(t);
    endtask

    task automatic tick();
        @(posedge tck_i);
        #1;
    endtask

    task automatic drain();
        @(negedge tck_i);
        #1;
    endtask

    task automatic do_capture();
        capture_dr_i = 1'b1;
        tick();
        capture_dr_i = 1'b0;
    endtask

    task automatic do_shift(input logic b);
        tdi_i      = b;
        shift_dr_i = 1'b1;
        tick();
        shift_dr_i = 1'b0;
        tdi_i      = 1'b0;
    endtask

    task automatic do_update();
        update_dr_i = 1'b1;
        tick();
        update_dr_i = 1'b0;
    endtask

    task automatic scan_word(input logic [63:0] w);
        do_capture();
        for (int i = 0; i < 64; i++) do_shift(w[i]);
        do_update();
    endtask

    task automatic scan_status(input string tag, input logic [7:0] st);
        logic [8:0] e;
        e = {1'b0, st};
        do_capture();
        push({tag, "_tdo0"}, K_TDO, {63'd0, e[0]});
        push({tag, "_sel_in_scan"}, K_SEL, 64'd0);
        drain();
        for (int k = 1; k <= 8; k++) begin
            do_shift(1'b0);
            push($sformatf("%s_tdo%0d", tag, k), K_TDO, {63'd0, e[k]});
            drain();
        end
        do_update();
    endtask

    localparam logic [63:0] CMD_ID1 = {1'b1, 5'd1, 58'd0};
    localparam logic [63:0] CMD_ID2 = {1'b1, 5'd2, 58'd0};
    localparam logic [63:0] CMD_ID3 = {1'b1, 5'd3, 58'd0};
    localparam logic [63:0] CMD_ID7 = {1'b1, 5'd7, 58'd0};
    localparam logic [63:0] NONSEL  = 64'h0123_4567_89AB_CDEF;

    initial begin
        logic [8:0] e;

        drain();
        push("rst_sel", K_SEL, 64'h1);
        push("rst_id", K_ID, 64'h0);
        push("rst_dr", K_DR, 64'h0);
        push("rst_tdo_m0_hi", K_TDO, 64'h1);
        drain();
        module_tdo_i = 4'b1110;
        #1;
        push("rst_tdo_m0_lo", K_TDO, 64'h0);
        drain();
        trstn_i = 1'b1;
        drain();

        do_capture();
        for (int i = 0; i < 10; i++) do_shift(1'b1);
        push("pre_rst_dr", K_DR, 64'hFFC0_0000_0000_0000);
        drain();
        module_tdo_i = 4'b0001;
        trstn_i = 1'b0;
        #1;
        push("midrst_dr", K_DR, 64'h0);
        push("midrst_sel", K_SEL, 64'h1);
        push("midrst_id", K_ID, 64'h0);
        push("midrst_tdo", K_TDO, 64'h1);
        drain();
        trstn_i = 1'b1;
        drain();

        scan_word(CMD_ID2);
        push("sel2_id", K_ID, 64'd2);
        push("sel2_sel_pending", K_SEL, 64'h0);
        push("sel2_dr", K_DR, CMD_ID2);
        drain();
        n_checks++;
        if (module_id_o !== 5'd2) begin
            n_err++;
            $display("FAIL sel2_id_direct: got %0d expected 2", module_id_o);
        end
        scan_status("st2", 8'b00_00010_1);
        push("sel2_sel_after", K_SEL, 64'b0100);
        drain();

        module_inhibit_i = 4'b0010;
        scan_word(CMD_ID3);
        module_inhibit_i = 4'b0000;
        push("inh_id", K_ID, 64'd2);
        push("inh_sel_pending", K_SEL, 64'h0);
        drain();
        scan_status("st_inh", 8'b01_00010_1);
        push("inh_sel_after", K_SEL, 64'b0100);
        drain();

        scan_word(CMD_ID7);
        push("oor_id", K_ID, 64'd2);
        drain();
        n_checks++;
        if (module_id_o !== 5'd2) begin
            n_err++;
            $display("FAIL oor_id_direct: got %0d expected 2", module_id_o);
        end
        scan_status("st_oor", 8'b10_00010_1);
        module_tdo_i = 4'b0100;
        #1;
        push("oor_tdo_m2_hi", K_TDO, 64'h1);
        drain();
        module_tdo_i = 4'b1011;
        #1;
        push("oor_tdo_m2_lo", K_TDO, 64'h0);
        drain();

        scan_word(NONSEL);
        push("nonsel_sel", K_SEL, 64'b0100);
        push("nonsel_dr", K_DR, NONSEL);
        push("nonsel_id", K_ID, 64'd2);
        drain();
        n_checks++;
        if (module_select_o !== 4'b0100) begin
            n_err++;
            $display("FAIL nonsel_sel_direct: got %b expected 0100", module_select_o);
        end
        module_tdo_i = 4'b0100;
        do_capture();
        push("nonsel_cap_sel", K_SEL, 64'b0100);
        push("nonsel_cap_tdo", K_TDO, 64'h1);
        drain();
        do_update();

        debug_select_i = 1'b0;
        do_shift(1'b1);
        do_shift(1'b1);
        do_capture();
        do_update();
        debug_select_i = 1'b1;
        push("nodbg_dr", K_DR, NONSEL);
        push("nodbg_sel", K_SEL, 64'b0100);
        drain();

        module_tdo_i = 4'b0001;
        scan_word(CMD_ID1);
        push("sel1_id", K_ID, 64'd1);
        drain();
        e = {1'b0, 8'b00_00001_1};
        do_capture();
        push("simul_tdo0", K_TDO, {63'd0, e[0]});
        drain();
        for (int i = 0; i < 64; i++) begin
            do_shift(CMD_ID3[i]);
            if (i < 8) begin
                push($sformatf("simul_tdo%0d", i + 1), K_TDO, {63'd0, e[i + 1]});
                drain();
            end
        end
        do_update();
        push("simul_id", K_ID, 64'd3);
        push("simul_sel_pending", K_SEL, 64'h0);
        push("simul_tdo_mux", K_TDO, 64'h0);
        drain();

        e = {1'b0, 8'b00_00011_1};
        do_capture();
        push("st3_tdo0", K_TDO, {63'd0, e[0]});
        drain();
        for (int k = 1; k <= 3; k++) begin
            do_shift(1'b0);
            push($sformatf("st3_tdo%0d", k), K_TDO, {63'd0, e[k]});
            drain();
        end
        trstn_i = 1'b0;
        #1;
        n_checks++;
        if (tdo_o !== 1'b1) begin
            n_err++;
            $display("FAIL st3_rst_tdo_direct: got %b expected 1", tdo_o);
        end
        n_checks++;
        if (module_id_o !== 5'd0) begin
            n_err++;
            $display("FAIL st3_rst_id_direct: got %0d expected 0", module_id_o);
        end
        push("st3_rst_tdo", K_TDO, 64'h1);
        push("st3_rst_sel", K_SEL, 64'h1);
        push("st3_rst_id", K_ID, 64'h0);
        drain();
        trstn_i = 1'b1;
        drain();
        do_capture();
        push("post_rst_cap_sel", K_SEL, 64'h1);
        push("post_rst_cap_tdo", K_TDO, 64'h1);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

endmodule
